hadamard_16pt: RTL and testbench
================================

Name: hadamard_16pt

Overview:
- 16-point Walsh-Hadamard transform engine in natural (Sylvester) ordering.
- Accepts 16 signed samples in parallel and produces 16 signed coefficients in parallel.
- Uses a 4-stage registered radix-2 butterfly pipeline.
- Sits in the DSP datapath as a fully parallel transform block; one new vector per clock is possible.

Parameters:
- W, 9, signed width of every input sample and output coefficient

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  input-vector strobe; x0..x15 are sampled on any rising edge where start=1
- x0..x15  in  W each, signed  input samples x[n], n=0..15
- y0..y15  out  W each, signed  transform outputs y[k]
- valid  out  1  one-cycle pulse; y0..y15 were updated on this edge

Behaviour:
- Function: y[k] = sum over n=0..15 of x[n]*(-1)^popcount(k AND n).
  - y0 is the plain sum.
  - y8 is (x0..x7 sum) minus (x8..x15 sum).
- Reset (rst=1 at a clock edge):
  - All pipeline data registers, y0..y15 and valid go to 0.
  - Any vectors in flight are discarded.
  - Reset has priority over start.
- Pipeline, one register per step:
  - S0: input capture register, loaded only when start=1, with a valid bit equal to start.
  - S1..S4: butterfly stages. Stage s (s=1..4) pairs element i with i+2^(s-1), for every i whose bit (s-1) is 0:
    - a' = a+b
    - b' = a-b
    - Results stay in place, so the output is in natural order and no bit reversal is needed.
  - Output register: loaded from S4 only when the S4 valid bit is 1; otherwise y0..y15 hold their last value.
- Latency: start sampled at edge N -> y and valid updated at edge N+5.
- Throughput: one vector per cycle when start is held high. Each sampled vector produces exactly one valid pulse. Back-to-back vectors are never dropped.
- When start=0, the valid bit entering S0 is 0 (a bubble). The data lanes may advance freely.
- Internal widths are full precision with no overflow: W+1, W+2, W+3 and W+4 bits after stages 1-4 (13 bits for W=9). All arithmetic is two's-complement signed.
- Output narrowing from W+4 to W bits: see Optional Feature.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: HADAMARD_16PT_SAT_EN
- Defined:
  - Each W+4-bit result is saturated to the W-bit signed range [-2^(W-1), 2^(W-1)-1], i.e. [-256, 255] for W=9.
  - Optional extra: a sticky output register sat_flag, set on any clamp and cleared by rst.
- Undefined:
  - Results are truncated to the low W bits (modular wrap).
  - No sat_flag port.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst for 2 cycles with start=1, then deassert rst; start=0 throughout idle.
  - Required: all y = 0 and valid = 0 during reset. With start=0 after reset, no valid pulse appears and y holds.
- Vector A:
  - Stimulus: x = 2,-1,2,-3,1,-2,3,0,5,1,-2,-1,2,4,6,-1 with start=1 for one edge.
  - Required: 5 edges later valid=1, y0=16, y1=22, y8=-12. All 16 outputs match a software reference.
- Vector B:
  - Stimulus: x = 1,0,0,-1,2,3,-1,-1,0,1,2,0,0,5,8,0.
  - Required: y0=19. All 16 outputs match the software reference.
- Impulses:
  - Stimulus: x0=1, others 0.
  - Required: all y=1.
  - Stimulus: x15=1, others 0.
  - Required: y[k] = (-1)^popcount(k), i.e. y0=1, y1=-1, y2=-1, y3=1, ..., y15=1.
- Back-to-back streaming:
  - Stimulus: start held high while 4 different vectors are applied on consecutive edges, with rst pulsed mid-stream on one run.
  - Required without rst: 4 consecutive valid pulses with the results in order.
  - Required with rst: in-flight results are suppressed, and y=0 after reset.
- Overflow:
  - Stimulus: all x=255, then all x=-256.
  - Required with HADAMARD_16PT_SAT_EN: y0=255, then y0=-256.
  - Required without it: y0=-16, then y0=0.
  - Required in both builds: y1..y15 = 0.

Source files
------------

// File: rtl/hadamard_16pt.sv
// -----------------------------------------------------------------------------
// hadamard_16pt
//
// 16-point Walsh-Hadamard transform, natural (Sylvester) ordering:
//   y[k] = sum_{n=0..15} x[n] * (-1)^popcount(k & n)
// A 16-wide input vector goes through an input capture register, four
// registered radix-2 butterfly stages and an output register. It accepts one
// vector per clock. Latency is five edges from the start strobe to valid.
//
// Parameters
//   W         signed width of every input sample and output coefficient
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset; discards all vectors in flight
//   start     input strobe; x0..x15 are captured on every edge with start=1
//   x0..x15   signed input samples
//   y0..y15   signed transform outputs, held between results
//   valid     one-cycle pulse; y0..y15 were updated on this edge
//   sat_flag  (HADAMARD_16PT_SAT_EN only) sticky flag, set whenever an
//             output was clamped, cleared by rst
//
// Configuration
//   HADAMARD_16PT_SAT_EN  when defined, the W+4-bit results saturate to the
//                         W-bit signed range. When undefined they wrap to
//                         their low W bits.
// -----------------------------------------------------------------------------
module hadamard_16pt #(
  parameter int W = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [W-1:0] x0,
  input  logic signed [W-1:0] x1,
  input  logic signed [W-1:0] x2,
  input  logic signed [W-1:0] x3,
  input  logic signed [W-1:0] x4,
  input  logic signed [W-1:0] x5,
  input  logic signed [W-1:0] x6,
  input  logic signed [W-1:0] x7,
  input  logic signed [W-1:0] x8,
  input  logic signed [W-1:0] x9,
  input  logic signed [W-1:0] x10,
  input  logic signed [W-1:0] x11,
  input  logic signed [W-1:0] x12,
  input  logic signed [W-1:0] x13,
  input  logic signed [W-1:0] x14,
  input  logic signed [W-1:0] x15,
  output logic signed [W-1:0] y0,
  output logic signed [W-1:0] y1,
  output logic signed [W-1:0] y2,
  output logic signed [W-1:0] y3,
  output logic signed [W-1:0] y4,
  output logic signed [W-1:0] y5,
  output logic signed [W-1:0] y6,
  output logic signed [W-1:0] y7,
  output logic signed [W-1:0] y8,
  output logic signed [W-1:0] y9,
  output logic signed [W-1:0] y10,
  output logic signed [W-1:0] y11,
  output logic signed [W-1:0] y12,
  output logic signed [W-1:0] y13,
  output logic signed [W-1:0] y14,
  output logic signed [W-1:0] y15,
  output logic                valid
`ifdef HADAMARD_16PT_SAT_EN
  ,
  output logic                sat_flag
`endif
);

  // Each butterfly stage grows the word by one bit, so nothing can overflow.
  localparam int W1 = W + 1;
  localparam int W2 = W + 2;
  localparam int W3 = W + 3;
  localparam int W4 = W + 4;

  logic signed [W-1:0]  x_arr [16];

  logic signed [W-1:0]  s0_q [16];
  logic signed [W1-1:0] s1_d [16];
  logic signed [W1-1:0] s1_q [16];
  logic signed [W2-1:0] s2_d [16];
  logic signed [W2-1:0] s2_q [16];
  logic signed [W3-1:0] s3_d [16];
  logic signed [W3-1:0] s3_q [16];
  logic signed [W4-1:0] s4_d [16];
  logic signed [W4-1:0] s4_q [16];
  logic signed [W-1:0]  y_d  [16];
  logic signed [W-1:0]  y_q  [16];

  logic v0_q, v1_q, v2_q, v3_q, v4_q, valid_q;

  assign x_arr[0]  = x0;
  assign x_arr[1]  = x1;
  assign x_arr[2]  = x2;
  assign x_arr[3]  = x3;
  assign x_arr[4]  = x4;
  assign x_arr[5]  = x5;
  assign x_arr[6]  = x6;
  assign x_arr[7]  = x7;
  assign x_arr[8]  = x8;
  assign x_arr[9]  = x9;
  assign x_arr[10] = x10;
  assign x_arr[11] = x11;
  assign x_arr[12] = x12;
  assign x_arr[13] = x13;
  assign x_arr[14] = x14;
  assign x_arr[15] = x15;

  // Stage s pairs lane i with lane i|2^(s-1) for every i with that bit clear.
  // The sum stays in the lower lane and the difference goes to the upper
  // lane. This in-place layout gives natural ordering with no bit reversal.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    s1_d = '{default: '0};
    for (int i = 0; i < 16; i++) begin
      if ((i & 1) == 0) begin
        s1_d[i]     = W1'(s0_q[i]) + W1'(s0_q[i | 1]);
        s1_d[i | 1] = W1'(s0_q[i]) - W1'(s0_q[i | 1]);
      end
    end
  end

  always_comb begin
    s2_d = '{default: '0};
    for (int i = 0; i < 16; i++) begin
      if ((i & 2) == 0) begin
        s2_d[i]     = W2'(s1_q[i]) + W2'(s1_q[i | 2]);
        s2_d[i | 2] = W2'(s1_q[i]) - W2'(s1_q[i | 2]);
      end
    end
  end

  always_comb begin
    s3_d = '{default: '0};
    for (int i = 0; i < 16; i++) begin
      if ((i & 4) == 0) begin
        s3_d[i]     = W3'(s2_q[i]) + W3'(s2_q[i | 4]);
        s3_d[i | 4] = W3'(s2_q[i]) - W3'(s2_q[i | 4]);
      end
    end
  end

  always_comb begin
    s4_d = '{default: '0};
    for (int i = 0; i < 16; i++) begin
      if ((i & 8) == 0) begin
        s4_d[i]     = W4'(s3_q[i]) + W4'(s3_q[i | 8]);
        s4_d[i | 8] = W4'(s3_q[i]) - W4'(s3_q[i | 8]);
      end
    end
  end

  // Narrow the full-precision results to W bits.
`ifdef HADAMARD_16PT_SAT_EN
  localparam logic signed [W4-1:0] SAT_MAX = W4'(2 ** (W - 1) - 1);
  localparam logic signed [W4-1:0] SAT_MIN = W4'(-(2 ** (W - 1)));

  logic clamp_any;
  logic sat_flag_q;

  always_comb begin
    y_d       = '{default: '0};
    clamp_any = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (s4_q[k] > SAT_MAX) begin
        y_d[k]    = SAT_MAX[W-1:0];
        clamp_any = 1'b1;
      end else if (s4_q[k] < SAT_MIN) begin
        y_d[k]    = SAT_MIN[W-1:0];
        clamp_any = 1'b1;
      end else begin
        y_d[k] = s4_q[k][W-1:0];
      end
    end
  end
`else
  // Wrap mode keeps only the low W bits. The discarded high bits are folded
  // into a sink signal so they are not reported as unused.
  logic unused_s4_hi;

  always_comb begin
    y_d          = '{default: '0};
    unused_s4_hi = 1'b0;
    for (int k = 0; k < 16; k++) begin
      y_d[k]       = s4_q[k][W-1:0];
      unused_s4_hi = unused_s4_hi ^ (^s4_q[k][W4-1:W]);
    end
  end
`endif

  // Data lanes in S1..S4 advance every cycle. Only the valid bits decide
  // which results reach the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the pipeline arrays are ordinary flops, not RAM. They are
      // reset explicitly so that y reads 0 after reset and no stale lane
      // data can show up.
      s0_q    <= '{default: '0};
      s1_q    <= '{default: '0};
      s2_q    <= '{default: '0};
      s3_q    <= '{default: '0};
      s4_q    <= '{default: '0};
      y_q     <= '{default: '0};
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      v4_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here make every stage read the value
      // its predecessor held before this edge, so the assignment order does
      // not matter.
      v0_q <= start;
      if (start) s0_q <= x_arr;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      s4_q    <= s4_d;
      v1_q    <= v0_q;
      v2_q    <= v1_q;
      v3_q    <= v2_q;
      v4_q    <= v3_q;
      valid_q <= v4_q;
      if (v4_q) y_q <= y_d;
    end
  end

`ifdef HADAMARD_16PT_SAT_EN
  // Only clamps on real (valid) vectors count. Bubbles are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag_q <= 1'b0;
    end else if (v4_q && clamp_any) begin
      sat_flag_q <= 1'b1;
    end
  end

  assign sat_flag = sat_flag_q;
`endif

  assign y0    = y_q[0];
  assign y1    = y_q[1];
  assign y2    = y_q[2];
  assign y3    = y_q[3];
  assign y4    = y_q[4];
  assign y5    = y_q[5];
  assign y6    = y_q[6];
  assign y7    = y_q[7];
  assign y8    = y_q[8];
  assign y9    = y_q[9];
  assign y10   = y_q[10];
  assign y11   = y_q[11];
  assign y12   = y_q[12];
  assign y13   = y_q[13];
  assign y14   = y_q[14];
  assign y15   = y_q[15];
  assign valid = valid_q;

endmodule

// File: tb/tb_hadamard_16pt.sv
// -----------------------------------------------------------------------------
// tb_hadamard_16pt
//
// Directed testbench for hadamard_16pt. Expected coefficients come from a
// direct evaluation of sum x[n]*(-1)^popcount(k&n), narrowed the same way as
// the build (saturate with HADAMARD_16PT_SAT_EN, wrap otherwise). Key values
// are also checked against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_hadamard_16pt;

  localparam int W     = 9;
  localparam int Y_MAX = (1 << (W - 1)) - 1;
  localparam int Y_MIN = -(1 << (W - 1));

  typedef int vec_t [16];

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic signed [W-1:0] x_tb [16];
  logic signed [W-1:0] y_w  [16];
  logic                valid_w;
`ifdef HADAMARD_16PT_SAT_EN
  logic                sat_flag_w;
`endif

  int checks = 0;
  int errors = 0;
  int exp_y [16];
  int exp_s [4][16];

  always #5 clk = ~clk;

  hadamard_16pt #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x0    (x_tb[0]),  .x1  (x_tb[1]),  .x2  (x_tb[2]),  .x3  (x_tb[3]),
    .x4    (x_tb[4]),  .x5  (x_tb[5]),  .x6  (x_tb[6]),  .x7  (x_tb[7]),
    .x8    (x_tb[8]),  .x9  (x_tb[9]),  .x10 (x_tb[10]), .x11 (x_tb[11]),
    .x12   (x_tb[12]), .x13 (x_tb[13]), .x14 (x_tb[14]), .x15 (x_tb[15]),
    .y0    (y_w[0]),   .y1  (y_w[1]),   .y2  (y_w[2]),   .y3  (y_w[3]),
    .y4    (y_w[4]),   .y5  (y_w[5]),   .y6  (y_w[6]),   .y7  (y_w[7]),
    .y8    (y_w[8]),   .y9  (y_w[9]),   .y10 (y_w[10]),  .y11 (y_w[11]),
    .y12   (y_w[12]),  .y13 (y_w[13]),  .y14 (y_w[14]),  .y15 (y_w[15]),
    .valid (valid_w)
`ifdef HADAMARD_16PT_SAT_EN
    ,
    .sat_flag (sat_flag_w)
`endif
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int narrow(input int v);
`ifdef HADAMARD_16PT_SAT_EN
    if (v > Y_MAX) return Y_MAX;
    if (v < Y_MIN) return Y_MIN;
    return v;
`else
    logic signed [W-1:0] t;
    t = v[W-1:0];
    return int'(t);
`endif
  endfunction

  task automatic set_x(input vec_t v);
    for (int i = 0; i < 16; i++) x_tb[i] = W'(v[i]);
  endtask

  // Reference: direct sign-pattern sum, independent of the butterfly layout.
  task automatic compute_expected();
    int acc;
    for (int k = 0; k < 16; k++) begin
      acc = 0;
      for (int n = 0; n < 16; n++) begin
        if (($countones(k & n) % 2) == 1) acc -= int'(x_tb[n]);
        else                              acc += int'(x_tb[n]);
      end
      exp_y[k] = narrow(acc);
    end
  endtask

  // Advance one edge, then settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_y(input string tag);
    for (int k = 0; k < 16; k++)
      check($sformatf("%s_y%0d", tag, k), y_w[k], exp_y[k]);
  endtask

  // One isolated vector: checks the exact 5-edge latency, a single valid
  // pulse, all outputs, and that y holds afterwards.
  task automatic run_vec(input string tag, input vec_t v);
    set_x(v);
    compute_expected();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("%s_lat%0d_valid", tag, i), valid_w, 1'b0);
    end
    step();
    check({tag, "_valid"}, valid_w, 1'b1);
    check_y(tag);
    step();
    check({tag, "_pulse_end"}, valid_w, 1'b0);
    check({tag, "_hold_y0"}, y_w[0], exp_y[0]);
  endtask

  vec_t va    = '{2, -1, 2, -3, 1, -2, 3, 0, 5, 1, -2, -1, 2, 4, 6, -1};
  vec_t vb    = '{1, 0, 0, -1, 2, 3, -1, -1, 0, 1, 2, 0, 0, 5, 8, 0};
  vec_t vc    = '{3, 1, 4, 1, 5, -9, 2, 6, -5, 3, 5, -8, 9, 7, -9, 3};
  vec_t vd    = '{-7, 0, 12, -4, 8, 8, -1, 2, 0, -3, 6, 1, -10, 4, 5, -2};
  vec_t imp0  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  vec_t imp15 = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
  vec_t vmax  = '{default: 255};
  vec_t vmin  = '{default: -256};
  vec_t sv [4];

  initial begin
    sv[0] = va;
    sv[1] = vb;
    sv[2] = vc;
    sv[3] = vd;

    // Reset held for two edges while start=1: reset wins, outputs stay 0.
    rst   = 1'b1;
    start = 1'b1;
    set_x(va);
    for (int r = 0; r < 2; r++) begin
      step();
      check($sformatf("rst%0d_valid", r), valid_w, 1'b0);
      for (int k = 0; k < 16; k++)
        check($sformatf("rst%0d_y%0d", r, k), y_w[k], 0);
    end
`ifdef HADAMARD_16PT_SAT_EN
    check("rst_sat_flag", sat_flag_w, 1'b0);
`endif

    // Idle: no strobe means no pulse, and y holds at 0.
    rst   = 1'b0;
    start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      check($sformatf("idle%0d_valid", c), valid_w, 1'b0);
      check($sformatf("idle%0d_y0", c), y_w[0], 0);
    end

    // Vector A with hand-computed key coefficients.
    run_vec("vecA", va);
    check("vecA_hand_y0", y_w[0], 16);
    check("vecA_hand_y1", y_w[1], 22);
    check("vecA_hand_y8", y_w[8], -12);

    run_vec("vecB", vb);
    check("vecB_hand_y0", y_w[0], 19);

    // Impulses.
    run_vec("imp0", imp0);
    for (int k = 0; k < 16; k++)
      check($sformatf("imp0_hand_y%0d", k), y_w[k], 1);
    run_vec("imp15", imp15);
    check("imp15_hand_y0", y_w[0], 1);
    check("imp15_hand_y1", y_w[1], -1);
    check("imp15_hand_y2", y_w[2], -1);
    check("imp15_hand_y3", y_w[3], 1);
    check("imp15_hand_y7", y_w[7], -1);
    check("imp15_hand_y15", y_w[15], 1);

    // Back-to-back streaming: four vectors on consecutive edges.
    start = 1'b1;
    for (int j = 0; j < 4; j++) begin
      set_x(sv[j]);
      compute_expected();
      exp_s[j] = exp_y;
      step();
      check($sformatf("strm_in%0d_valid", j), valid_w, 1'b0);
    end
    start = 1'b0;
    step();
    check("strm_gap_valid", valid_w, 1'b0);
    for (int j = 0; j < 4; j++) begin
      step();
      check($sformatf("strm_out%0d_valid", j), valid_w, 1'b1);
      for (int k = 0; k < 16; k++)
        check($sformatf("strm_out%0d_y%0d", j, k), y_w[k], exp_s[j][k]);
    end
    step();
    check("strm_end_valid", valid_w, 1'b0);

    // Streaming with a mid-stream reset: in-flight vectors are discarded.
    start = 1'b1;
    set_x(sv[0]);
    step();
    set_x(sv[1]);
    step();
    rst = 1'b1;
    set_x(sv[2]);
    step();
    check("strm_rst_valid", valid_w, 1'b0);
    for (int k = 0; k < 16; k++)
      check($sformatf("strm_rst_y%0d", k), y_w[k], 0);
    rst   = 1'b0;
    start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      check($sformatf("strm_rst_after%0d_valid", c), valid_w, 1'b0);
      check($sformatf("strm_rst_after%0d_y0", c), y_w[0], 0);
    end

    // Overflow on y0; every other coefficient cancels to zero.
    run_vec("ovf_max", vmax);
`ifdef HADAMARD_16PT_SAT_EN
    check("ovf_max_hand_y0", y_w[0], 255);
    check("ovf_max_sat_flag", sat_flag_w, 1'b1);
`else
    check("ovf_max_hand_y0", y_w[0], -16);
`endif
    for (int k = 1; k < 16; k++)
      check($sformatf("ovf_max_hand_y%0d", k), y_w[k], 0);

    run_vec("ovf_min", vmin);
`ifdef HADAMARD_16PT_SAT_EN
    check("ovf_min_hand_y0", y_w[0], -256);
`else
    check("ovf_min_hand_y0", y_w[0], 0);
`endif
    for (int k = 1; k < 16; k++)
      check($sformatf("ovf_min_hand_y%0d", k), y_w[k], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
